// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_buf.sv
// Circular store pairing each requested PC with its returned instruction word.
// Entries are allocated at request time and filled in request order.
module fetch_entry_buf
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clear_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_instr_i,
    input  logic            pop_i,
    output fetch_entry_t    head_o,
    output logic [CntW-1:0] count_o
);

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [PtrW-1:0] fill_q, fill_d;
    logic [CntW-1:0] count_q, count_d;
    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        fill_d  = fill_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            fill_d  = '0;
            count_d = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i].filled = 1'b0;
            end
        end else begin
            // Popped slots drop their filled flag so a wrapped head never looks valid.
            if (pop_i) begin
                mem_d[head_q].filled = 1'b0;
                head_d               = head_q + 1'b1;
            end
            if (alloc_i) begin
                mem_d[tail_q].pc     = alloc_pc_i;
                mem_d[tail_q].instr  = '0;
                mem_d[tail_q].filled = 1'b0;
                tail_d               = tail_q + 1'b1;
            end
            if (fill_i) begin
                mem_d[fill_q].instr  = fill_instr_i;
                mem_d[fill_q].filled = 1'b1;
                fill_d               = fill_q + 1'b1;
            end
            count_d = count_q + CntW'(alloc_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester: owns the PC, issues in-order word requests and
// presents {instr, pc} pairs; redirects flush the buffer and drop stale responses.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CntW-1:0] inflight_q, inflight_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0] count;
    fetch_entry_t    head;
    logic            req_fire;
    logic            rsp_drop;
    logic            fill;
    logic            pop;

    always_comb begin
        mem_req_valid = !reset && !redirect_valid && (count < MaxCnt) && (inflight_q < MaxCnt);
        mem_req_addr  = pc_q;
        req_fire      = mem_req_valid && mem_req_ready;

        rsp_drop = mem_rsp_valid && (drop_cnt_q != '0);
        fill     = mem_rsp_valid && !rsp_drop && !redirect_valid;

        out_valid = !reset && head.filled;
        out_instr = reset ? '0 : head.instr;
        out_pc    = reset ? '0 : head.pc;
        pop       = out_valid && out_ready && !redirect_valid;

        inflight_d = inflight_q + CntW'(req_fire) - CntW'(mem_rsp_valid);

        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            drop_cnt_d = inflight_d;
        end else if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end

        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h3;
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_entry_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i        (clk),
        .reset_i      (reset),
        .clear_i      (redirect_valid),
        .alloc_i      (req_fire),
        .alloc_pc_i   (pc_q),
        .fill_i       (fill),
        .fill_instr_i (mem_rsp_data),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table plus redirect/reset sequences
// against an in-order memory model with programmable latency.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend_q[$];
    int    cyc = 0;
    int    lat = 1;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive this cycle's memory response, then let combinational outputs settle.
    task automatic prep();
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = word(pend_q[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        #1;
    endtask

    // Record handshakes, cross the active edge, update the memory model.
    task automatic adv();
        logic        fire;
        logic [31:0] addr;
        logic        rsp;
        logic        rst;
        fire = (mem_req_valid === 1'b1) && mem_req_ready;
        addr = mem_req_addr;
        rsp  = mem_rsp_valid;
        rst  = reset;
        @(posedge clk);
        if (rsp) void'(pend_q.pop_front());
        if (fire) pend_q.push_back('{addr: addr, due: cyc + lat});
        if (rst) pend_q.delete();
        if (pend_q.size() > 2) begin
            errors++;
            $display("FAIL outstanding_limit: got %0d expected <= 2", pend_q.size());
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        prep();
        adv();
        reset = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [31:0] exp_pc, input int budget);
        for (int i = 0; i < budget; i++) begin
            prep();
            if (out_valid === 1'b1) begin
                check({name, "_pc"}, out_pc, exp_pc);
                check({name, "_instr"}, out_instr, word(exp_pc));
                adv();
                return;
            end
            adv();
        end
        errors++;
        $display("FAIL %s_timeout: got no out_valid expected pc %h", name, exp_pc);
    endtask

    typedef struct {
        logic        rst;
        logic        req_rdy;
        logic        out_rdy;
        logic        exp_req_v;
        logic [31:0] exp_addr;
        logic        exp_out_v;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic rr, input logic orr, input logic rv,
                                input logic [31:0] a, input logic ov, input logic [31:0] p);
        vec_t v;
        v.rst       = rst;
        v.req_rdy   = rr;
        v.out_rdy   = orr;
        v.exp_req_v = rv;
        v.exp_addr  = a;
        v.exp_out_v = ov;
        v.exp_pc    = p;
        return v;
    endfunction

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b1;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        out_ready      = 1'b1;

        // Reset, then sequential fetch with 1-cycle memory.
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h00, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h04, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h00));
        vecs.push_back(mk(0, 1, 1, 1, 32'h08, 1, 32'h04));
        vecs.push_back(mk(0, 1, 1, 1, 32'h0C, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h08));
        vecs.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h0C));
        vecs.push_back(mk(0, 1, 1, 1, 32'h14, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h10));
        // Output backpressure: buffer fills, issue stops, then drains in order.
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 32'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 32'h04, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 32'h00));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 32'h00));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 32'h00));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h00));
        vecs.push_back(mk(0, 1, 1, 1, 32'h08, 1, 32'h04));
        vecs.push_back(mk(0, 1, 1, 1, 32'h0C, 0, 0));
        // Memory stall: address held, nothing allocated.
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 1, 32'h00, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h00, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h04, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h00));

        @(negedge clk);
        lat = 1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset         = vecs[i].rst;
            mem_req_ready = vecs[i].req_rdy;
            out_ready     = vecs[i].out_rdy;
            prep();
            check($sformatf("vec%0d_req_valid", i), 32'(mem_req_valid), 32'(vecs[i].exp_req_v));
            if (vecs[i].exp_req_v)
                check($sformatf("vec%0d_req_addr", i), mem_req_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_out_v));
            if (vecs[i].rst) begin
                check($sformatf("vec%0d_rst_pc", i), out_pc, 32'h0);
                check($sformatf("vec%0d_rst_instr", i), out_instr, 32'h0);
            end else if (vecs[i].exp_out_v) begin
                check($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d_out_instr", i), out_instr, word(vecs[i].exp_pc));
            end
            adv();
        end
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;

        // Redirect with two requests in flight on 3-cycle memory.
        do_reset();
        lat = 3;
        prep(); adv();
        prep(); adv();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        prep();
        check("rdr2_req_blocked", 32'(mem_req_valid), 32'h0);
        adv();
        redirect_valid = 1'b0;
        prep();
        check("rdr2_drain_cap", 32'(mem_req_valid), 32'h0);
        check("rdr2_out_flushed", 32'(out_valid), 32'h0);
        adv();
        prep();
        check("rdr2_new_req_valid", 32'(mem_req_valid), 32'h1);
        check("rdr2_new_req_addr", mem_req_addr, 32'h0000_0100);
        adv();
        wait_out("rdr2_first", 32'h0000_0100, 20);
        wait_out("rdr2_second", 32'h0000_0104, 20);

        // Redirect coincident with a response and a pop.
        do_reset();
        lat = 1;
        prep(); adv();
        prep(); adv();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        prep();
        check("rdrc_pre_out_valid", 32'(out_valid), 32'h1);
        check("rdrc_pre_rsp", 32'(mem_rsp_valid), 32'h1);
        check("rdrc_req_blocked", 32'(mem_req_valid), 32'h0);
        adv();
        redirect_valid = 1'b0;
        prep();
        check("rdrc_out_flushed", 32'(out_valid), 32'h0);
        check("rdrc_req_valid", 32'(mem_req_valid), 32'h1);
        check("rdrc_req_addr", mem_req_addr, 32'h0000_0200);
        adv();
        wait_out("rdrc_first", 32'h0000_0200, 20);

        // Reset mid-operation: count=2, one response still in flight.
        do_reset();
        lat       = 3;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prep(); adv();
        end
        reset = 1'b1;
        prep();
        check("rstmid_req_valid", 32'(mem_req_valid), 32'h0);
        check("rstmid_out_valid", 32'(out_valid), 32'h0);
        check("rstmid_out_pc", out_pc, 32'h0);
        check("rstmid_out_instr", out_instr, 32'h0);
        check("rstmid_late_rsp", 32'(mem_rsp_valid), 32'h1);
        adv();
        reset = 1'b0;
        prep();
        check("rstpost_out_valid", 32'(out_valid), 32'h0);
        check("rstpost_out_pc", out_pc, 32'h0);
        check("rstpost_req_valid", 32'(mem_req_valid), 32'h1);
        check("rstpost_req_addr", mem_req_addr, 32'h0);
        adv();
        out_ready = 1'b1;
        wait_out("rstpost_first", 32'h0, 20);
        wait_out("rstpost_second", 32'h4, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
